seg_display_scan: RTL and testbench

Display-side counterpart to the button-driven calculator core. The block accepts a binary result word with a load strobe and converts it to BCD with a sequential double-dabble engine. It then drives a multiplexed common-anode 7-segment display, scanning one digit at a time. It sits between the arithmetic core's result register and the board's segment/anode pins.

---
 rtl/seg_display_scan.sv | 175 +++++++++++++++++
 tb/tb_seg_display_scan.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg_display_scan.sv
// Binary-to-BCD display driver: sequential double-dabble conversion feeding a
// multiplexed 7-segment scan with leading-zero blanking and overflow dashes.
module seg_display_scan #(
    parameter int IN_W       = 8,
    parameter int DIGITS     = 3,
    parameter int SCAN_DIV   = 1000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IN_W-1:0]   value,
    input  logic              load,
    input  logic              blank_lz,
    output logic              busy,
    output logic [6:0]        seg,
    output logic              dp,
    output logic [DIGITS-1:0] an
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic POL = (ACTIVE_LOW != 0);

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t            state;
    logic [IN_W-1:0]   shift;
    logic [BCD_W-1:0]  bcd;
    logic              ovf;
    logic [CNT_W-1:0]  iter;
    logic [BCD_W-1:0]  disp_bcd;
    logic              disp_ovf;

    logic [BCD_W-1:0]  bcd_adj;
    logic [BCD_W-1:0]  next_bcd;
    logic [IN_W-1:0]   next_shift;
    logic              next_ovf;

    logic [PRE_W-1:0]  pre;
    logic [IDX_W-1:0]  idx;
    logic [DIGITS-1:0] lead_zero;
    logic              seen_nonzero;
    logic [3:0]        sel_nib;
    logic              sel_lz;
    logic [6:0]        seg_hi;
    logic [DIGITS-1:0] an_hi;

    function automatic logic [6:0] decode(input logic [3:0] nib);
        case (nib)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h00;
        endcase
    endfunction

    // One double-dabble step: add-3 correction on every nibble, then shift.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        next_bcd   = {bcd_adj[BCD_W-2:0], shift[IN_W-1]};
        next_shift = {shift[IN_W-2:0], 1'b0};
        next_ovf   = ovf | bcd_adj[BCD_W-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            shift    <= '0;
            bcd      <= '0;
            ovf      <= 1'b0;
            iter     <= '0;
            disp_bcd <= '0;
            disp_ovf <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        shift <= value;
                        bcd   <= '0;
                        ovf   <= 1'b0;
                        iter  <= '0;
                        busy  <= 1'b1;
                        state <= CONV;
                    end
                end
                CONV: begin
                    shift <= next_shift;
                    bcd   <= next_bcd;
                    ovf   <= next_ovf;
                    iter  <= iter + CNT_W'(1);
                    // Publish on the last iteration so partial results never show.
                    if (iter == CNT_W'(IN_W - 1)) begin
                        disp_bcd <= next_bcd;
                        disp_ovf <= next_ovf;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A digit is a leading zero when it and everything above it is zero; digit 0 never is.
    always_comb begin
        seen_nonzero = 1'b0;
        lead_zero    = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (disp_bcd[4*i +: 4] != 4'd0) begin
                seen_nonzero = 1'b1;
            end
            lead_zero[i] = !seen_nonzero && (i != 0);
        end
    end

    always_comb begin
        sel_nib = 4'd0;
        sel_lz  = 1'b0;
        an_hi   = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                sel_nib  = disp_bcd[4*i +: 4];
                sel_lz   = lead_zero[i];
                an_hi[i] = 1'b1;
            end
        end
        if (disp_ovf) begin
            seg_hi = 7'h40;
        end else if (blank_lz && sel_lz) begin
            seg_hi = 7'h00;
        end else begin
            seg_hi = decode(sel_nib);
        end
    end

    // Scan runs free of the converter; seg and an are registered together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre <= '0;
            idx <= '0;
            seg <= {7{POL}};
            an  <= {DIGITS{POL}};
            dp  <= POL;
        end else begin
            if (pre == PRE_W'(SCAN_DIV - 1)) begin
                pre <= '0;
                idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
            end else begin
                pre <= pre + PRE_W'(1);
            end
            seg <= seg_hi ^ {7{POL}};
            an  <= an_hi ^ {DIGITS{POL}};
            dp  <= POL;
        end
    end

endmodule

// File: tb/tb_seg_display_scan.sv
// Scoreboard bench for seg_display_scan: an 8-bit instance and a 10-bit instance
// (for overflow), both with a short scan divider, sharing one stimulus path.
module tb_seg_display_scan;

    typedef struct {
        int value;
        bit blank;
        int ndig;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       load;
    logic       blank_lz;
    logic       sel;
    logic [9:0] value;

    logic       busy_a, dp_a, busy_b, dp_b;
    logic [6:0] seg_a, seg_b;
    logic [2:0] an_a, an_b;

    logic       obs_busy, obs_dp;
    logic [6:0] obs_seg;
    logic [2:0] obs_an;

    int   tests_run;
    int   tests_failed;
    exp_t sbq[$];
    int   cnt;

    seg_display_scan #(.IN_W(8), .DIGITS(3), .SCAN_DIV(4), .ACTIVE_LOW(1)) dut_a (
        .clk(clk), .rst(rst), .value(value[7:0]), .load(load & ~sel),
        .blank_lz(blank_lz), .busy(busy_a), .seg(seg_a), .dp(dp_a), .an(an_a)
    );

    seg_display_scan #(.IN_W(10), .DIGITS(3), .SCAN_DIV(4), .ACTIVE_LOW(1)) dut_b (
        .clk(clk), .rst(rst), .value(value), .load(load & sel),
        .blank_lz(blank_lz), .busy(busy_b), .seg(seg_b), .dp(dp_b), .an(an_b)
    );

    assign obs_busy = sel ? busy_b : busy_a;
    assign obs_dp   = sel ? dp_b   : dp_a;
    assign obs_seg  = sel ? seg_b  : seg_a;
    assign obs_an   = sel ? an_b   : an_a;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        tests_run++;
        if (observed != expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Active-low segment pattern the display should show for digit d of v.
    function automatic int expSeg(input int v, input bit blank, input int d, input int ndig);
        int p;
        int lim;
        int dig;
        int code;
        int codes[10];
        codes = '{32'h3F, 32'h06, 32'h5B, 32'h4F, 32'h66, 32'h6D, 32'h7D, 32'h07, 32'h7F, 32'h6F};
        p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        lim = 1;
        for (int i = 0; i < ndig; i++) lim = lim * 10;
        dig = (v / p) % 10;
        if (v >= lim) code = 32'h40;
        else if (blank && d > 0 && v < p) code = 0;
        else code = codes[dig];
        return code ^ 32'h7F;
    endfunction

    // Assumes the caller is at a negedge; load is sampled on the next posedge.
    task automatic pulseLoad(input int v);
        value = 10'(v);
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    task automatic applyStimulus(input int v, input int ndig);
        exp_t e;
        e.value = v;
        e.blank = blank_lz;
        e.ndig  = ndig;
        sbq.push_back(e);
        pulseLoad(v);
    endtask

    // Counts negedge samples with busy high; bounded so a stuck busy still terminates.
    task automatic waitDone(output int n);
        n = 0;
        while (obs_busy && n < 50) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic checkDisplay();
        exp_t e;
        int   t;
        logic [2:0] target;
        if (sbq.size() == 0) begin
            checkOutput("sb_empty", 1, 0);
            return;
        end
        e = sbq.pop_front();
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            target = 3'b111 ^ (3'b001 << d);
            t = 0;
            while (obs_an !== target && t < 20) begin
                @(negedge clk);
                t++;
            end
            if (t == 20) begin
                checkOutput($sformatf("v%0d_d%0d_an_timeout", e.value, d), int'(obs_an), int'(target));
            end else begin
                checkOutput($sformatf("v%0d_d%0d_seg", e.value, d), int'(obs_seg),
                            expSeg(e.value, e.blank, d, e.ndig));
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst      = 1'b1;
        load     = 1'b0;
        blank_lz = 1'b0;
        sel      = 1'b0;
        value    = '0;

        repeat (3) @(negedge clk);
        checkOutput("rst_seg", int'(obs_seg), 32'h7F);
        checkOutput("rst_an", int'(obs_an), 32'h7);
        checkOutput("rst_busy", int'(obs_busy), 0);
        checkOutput("rst_dp", int'(obs_dp), 1);
        rst = 1'b0;

        // Each digit held for 4 cycles starting with digit 0 on the first edge.
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            checkOutput($sformatf("scan_an_%0d", i), int'(obs_an),
                        int'(3'b111 ^ (3'b001 << (((i - 1) / 4) % 3))));
            if (i == 1) checkOutput("first_seg", int'(obs_seg), 32'h40);
        end

        applyStimulus(173, 3);
        waitDone(cnt);
        checkOutput("busy_len_173", cnt, 8);
        checkDisplay();

        // Second load lands two cycles into the conversion and must be dropped.
        applyStimulus(255, 3);
        @(negedge clk);
        pulseLoad(12);
        waitDone(cnt);
        checkOutput("busy_len_255", cnt, 6);
        checkDisplay();

        // Load issued on the first cycle after busy falls must be accepted.
        pulseLoad(200);
        waitDone(cnt);
        applyStimulus(12, 3);
        waitDone(cnt);
        checkOutput("busy_len_12", cnt, 8);
        checkDisplay();

        blank_lz = 1'b1;
        applyStimulus(5, 3);
        waitDone(cnt);
        checkDisplay();
        applyStimulus(0, 3);
        waitDone(cnt);
        checkDisplay();
        applyStimulus(100, 3);
        waitDone(cnt);
        checkDisplay();
        blank_lz = 1'b0;

        sel = 1'b1;
        applyStimulus(1000, 3);
        waitDone(cnt);
        checkOutput("busy_len_1000", cnt, 10);
        checkDisplay();
        applyStimulus(999, 3);
        waitDone(cnt);
        checkDisplay();
        sel = 1'b0;

        applyStimulus(173, 3);
        waitDone(cnt);
        checkDisplay();
        pulseLoad(255);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort_busy", int'(obs_busy), 0);
        checkOutput("abort_seg", int'(obs_seg), 32'h7F);
        checkOutput("abort_an", int'(obs_an), 32'h7);
        rst = 1'b0;
        begin
            exp_t z;
            z.value = 0;
            z.blank = 1'b0;
            z.ndig  = 3;
            sbq.push_back(z);
        end
        checkDisplay();
        checkOutput("post_abort_busy", int'(obs_busy), 0);
        applyStimulus(42, 3);
        waitDone(cnt);
        checkOutput("busy_len_42", cnt, 8);
        checkDisplay();

        checkOutput("sb_leftover", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
